blob_bbox_tracker: RTL

- Sequences the fixed RGB565 colour-threshold classifier over the camera pixel stream.
- Per frame, counts matching pixels and tracks their bounding box.
- Publishes one result per frame through a valid/ack handshake to the CPU-side custom-instruction or DMA logic.
- Sits between the camera interface and the processor bus; pixels pass through untouched.

---
 rtl/blob_bbox_tracker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/blob_bbox_tracker.sv
// Per-frame colour-blob tracker: classifies RGB565 pixels, counts matches and
// bounding box, and hands one result per frame to the consumer via valid/ack.
module blob_bbox_tracker #(
  parameter int X_BITS     = 11,
  parameter int Y_BITS     = 10,
  parameter int CNT_BITS   = 20,
  parameter int MIN_PIXELS = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                newScreen,
  input  logic                newLine,
  input  logic                pixelValid,
  input  logic [15:0]         pixelData,
  output logic                resultValid,
  input  logic                resultAck,
  output logic                found,
  output logic [CNT_BITS-1:0] matchCount,
  output logic [X_BITS-1:0]   xMin,
  output logic [X_BITS-1:0]   xMax,
  output logic [Y_BITS-1:0]   yMin,
  output logic [Y_BITS-1:0]   yMax,
  output logic                overrun,
  output logic                busy
);
  localparam logic [X_BITS-1:0]   X_ONES  = '1;
  localparam logic [Y_BITS-1:0]   Y_ONES  = '1;
  localparam logic [CNT_BITS-1:0] C_ONES  = '1;
  localparam logic [CNT_BITS-1:0] MIN_CNT = CNT_BITS'(MIN_PIXELS);

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;
  state_t state_q, state_d;

  logic [X_BITS-1:0]   x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_BITS-1:0]   y_q, y_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                first_line_q, first_line_d;

  logic [X_BITS-1:0]   res_xmin_q, res_xmin_d, res_xmax_q, res_xmax_d;
  logic [Y_BITS-1:0]   res_ymin_q, res_ymin_d, res_ymax_q, res_ymax_d;
  logic [CNT_BITS-1:0] res_cnt_q, res_cnt_d;
  logic                res_valid_q, res_valid_d;
  logic                overrun_q, overrun_d;

  logic pix_match;
  logic frame_end;

  assign pix_match = (pixelData[15:14] == 2'b01) && (pixelData[10:8] == 3'b000) &&
                     (pixelData[4:3] == 2'b00) && (pixelData[2] | (pixelData[1] & pixelData[0]));
  assign frame_end = (state_q == TRACK) && newScreen;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (newScreen && enable)  state_d = TRACK;
      TRACK:   if (newScreen && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulators: reload on any frame boundary (or idle), then apply line and pixel.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    first_line_d = first_line_q;
    if ((state_q != TRACK) || newScreen) begin
      x_d          = '0;
      y_d          = '0;
      cnt_d        = '0;
      xmin_d       = X_ONES;
      xmax_d       = '0;
      ymin_d       = Y_ONES;
      ymax_d       = '0;
      first_line_d = ~newLine;
    end else if (newLine) begin
      x_d          = '0;
      first_line_d = 1'b0;
      if (!first_line_q && (y_q != Y_ONES)) y_d = y_q + 1'b1;
    end
    if ((state_d == TRACK) && pixelValid) begin
      if (pix_match) begin
        if (cnt_d != C_ONES) cnt_d = cnt_d + 1'b1;
        if (x_d < xmin_d) xmin_d = x_d;
        if (x_d > xmax_d) xmax_d = x_d;
        if (y_d < ymin_d) ymin_d = y_d;
        if (y_d > ymax_d) ymax_d = y_d;
      end
      if (x_d != X_ONES) x_d = x_d + 1'b1;
    end
  end

  // Handshake: valid/ready style, a result is accepted in a cycle where
  // resultValid=1 and resultAck=1; registers hold while resultValid=1.
  always_comb begin
    res_valid_d = res_valid_q;
    res_cnt_d   = res_cnt_q;
    res_xmin_d  = res_xmin_q;
    res_xmax_d  = res_xmax_q;
    res_ymin_d  = res_ymin_q;
    res_ymax_d  = res_ymax_q;
    overrun_d   = overrun_q;
    if (res_valid_q && resultAck) res_valid_d = 1'b0;
    if (frame_end) begin
      if (!res_valid_q || resultAck) begin
        res_valid_d = 1'b1;
        res_cnt_d   = cnt_q;
        res_xmin_d  = xmin_q;
        res_xmax_d  = xmax_q;
        res_ymin_d  = ymin_q;
        res_ymax_d  = ymax_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy        = (state_q == TRACK);
    resultValid = res_valid_q;
    found       = (res_cnt_q >= MIN_CNT);
    matchCount  = res_cnt_q;
    xMin        = res_xmin_q;
    xMax        = res_xmax_q;
    yMin        = res_ymin_q;
    yMax        = res_ymax_q;
    overrun     = overrun_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      xmin_q       <= X_ONES;
      xmax_q       <= '0;
      ymin_q       <= Y_ONES;
      ymax_q       <= '0;
      first_line_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_cnt_q    <= '0;
      res_xmin_q   <= X_ONES;
      res_xmax_q   <= '0;
      res_ymin_q   <= Y_ONES;
      res_ymax_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      first_line_q <= first_line_d;
      res_valid_q  <= res_valid_d;
      res_cnt_q    <= res_cnt_d;
      res_xmin_q   <= res_xmin_d;
      res_xmax_q   <= res_xmax_d;
      res_ymin_q   <= res_ymin_d;
      res_ymax_q   <= res_ymax_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule
